vault_share_tx: RTL and testbench
=================================

VAULT_SHARE_TX -- requirements
Module: vault_share_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, giving share queue entries; legal values are powers of two, 2..16.
REQ-003 clk  in  1  system clock; the module has one clock.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 share_valid  in  1  found-nonce event from the mining core.
REQ-006 share_nonce  in  32  golden nonce, sampled when share_valid && share_ready.
REQ-007 share_ready  out  1  queue not full; combinational from the FIFO count.
REQ-008 uart_txd  out  1  serial line to the pool; idles high.
REQ-009 busy  out  1  high while a frame is on the line or the queue is non-empty.
REQ-010 drop_count  out  16  shares lost because they arrived while share_valid && !share_ready.

Function
REQ-011 A share SHALL be pushed into the FIFO on a clk edge with share_valid && share_ready.
REQ-012 A frame SHALL be sent per share, in order: sync byte 0xA5, then nonce[31:24], [23:16], [15:8], [7:0].
REQ-013 Each byte SHALL be sent 8N1: start bit 0, data LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-014 The FSM states SHALL be IDLE, LOAD, START, DATA, STOP and NEXT.
- IDLE -> LOAD when FIFO non-empty.
- LOAD pops one entry.
- START -> DATA -> STOP per byte.
- NEXT selects the next byte, or returns to IDLE after the last byte.
REQ-015 Bytes within a frame SHALL be back-to-back, with no idle bits; consecutive frames SHALL also be back-to-back.
REQ-016 With an empty FIFO in IDLE, a share accepted at edge N SHALL drive uart_txd low from edge N+2.
REQ-017 share_ready SHALL be !full; a pop while full SHALL NOT raise share_ready in the same cycle.
- A push and a pop on the same edge, when not full, SHALL leave the count unchanged.
REQ-018 drop_count SHALL increment by 1 for each cycle with share_valid && !share_ready, saturating at 0xFFFF.
REQ-019 Changes to share_nonce after acceptance SHALL NOT affect a queued or in-flight frame.

Reset
REQ-020 Asserting rst_n low SHALL immediately (asynchronously) set:
- uart_txd = 1, busy = 0, drop_count = 0;
- FIFO empty, so share_ready = 1;
- FSM = IDLE.
REQ-021 Reset mid-frame SHALL abandon the frame; after release, no partial frame is resumed.

Configuration
REQ-022 Macro VAULT_SHARE_CHECKSUM_EN, when defined, SHALL append a sixth byte to each frame, equal to the XOR of the four nonce bytes.
- When the macro is undefined, frames SHALL be exactly 5 bytes.
- Without the macro, no checksum logic SHALL be instantiated.

Structure
REQ-023 A shared package SHALL hold:
- the sync byte constant 0xA5;
- frame length constants (5 without the macro, 6 with it);
- the FSM state encoding.
REQ-024 Bit timing and serialization SHALL live in one sub-module, vault_uart_tx_byte (byte in, start/done handshake, txd out).
- The frame FSM and the FIFO SHALL stay in vault_share_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-025 Single share 0xDEADBEEF with the macro defined -> line bytes A5 DE AD BE EF 22, frame lasts 240 clk, then busy = 0.
REQ-026 Same stimulus with the macro undefined -> bytes A5 DE AD BE EF, frame lasts 200 clk.
REQ-027 Six shares on consecutive cycles while idle:
- 5 accepted (1 popped by LOAD plus 4 queued);
- share_ready low for the 6th, drop_count = 1;
- 5 frames sent in order with no gap.
REQ-028 share_valid held high for 70000 cycles with the FIFO full -> drop_count saturates at 0xFFFF and does not wrap.
REQ-029 rst_n pulsed low during the DATA bits of byte 3 -> uart_txd = 1 in the same cycle, FIFO empty, and no bits on the line after release until a new share.
REQ-030 Bit-timing check: the start-bit low period measures exactly 4 clk, and a share accepted at edge N gives uart_txd low at edge N+2.

Source files
------------

// File: rtl/vault_share_pkg.sv
// vault_share_pkg: constants shared by the share transmitter slice.
// Holds the sync byte, the frame length, the frame FSM encoding and the
// bit-phase encoding of the byte serializer.
// The frame is 5 bytes, or 6 bytes when VAULT_SHARE_CHECKSUM_EN is defined.
package vault_share_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef VAULT_SHARE_CHECKSUM_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 5;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;

    typedef enum logic [1:0] {PH_IDLE, PH_START, PH_DATA, PH_STOP} tx_phase_e;

    // Nonce bytes go out most significant first; k = 1..4.
    function automatic logic [7:0] nonce_byte(input logic [31:0] n, input logic [2:0] k);
        return k == 3'd1 ? n[31:24] : k == 3'd2 ? n[23:16] : k == 3'd3 ? n[15:8] : n[7:0];
    endfunction

`ifdef VAULT_SHARE_CHECKSUM_EN
    function automatic logic [7:0] nonce_xor(input logic [31:0] n);
        return n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
    endfunction
`endif

endpackage

// File: rtl/vault_share_if.sv
// vault_share_if: share handshake from the mining core.
// Ports: share_valid (found-nonce event), share_nonce (golden nonce),
// share_ready (queue not full). master = mining core, slave = transmitter.
interface vault_share_if;
    logic        share_valid;
    logic [31:0] share_nonce;
    logic        share_ready;
    modport master (output share_valid, output share_nonce, input share_ready);
    modport slave  (input share_valid, input share_nonce, output share_ready);
endinterface

// File: rtl/vault_uart_tx_byte.sv
// vault_uart_tx_byte: 8N1 byte serializer with bit timing.
// Ports: clk, rst_n (async, active-low); start/din hand over a byte;
// txd is the serial line; phase reports the bit phase in progress;
// data_done flags the last cycle of data bit 7.
// A start seen during a stop bit is held and begins right after that stop
// bit ends, so the frame FSM can queue the next byte without a line gap.
module vault_uart_tx_byte
    import vault_share_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] din,
    output logic       txd,
    output tx_phase_e  phase,
    output logic       data_done
);

    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  sh;
    logic [7:0]  pbuf;
    logic        pend;
    logic        bit_end;
    logic        go;
    logic [7:0]  nb;

    assign bit_end   = cnt == 16'(CLKS_PER_BIT - 1);
    assign go        = pend | start;
    assign nb        = pend ? pbuf : din;
    assign data_done = phase == PH_DATA && bit_end && idx == 3'd7;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            pbuf  <= '0;
            pend  <= 1'b0;
            txd   <= 1'b1;
        end else begin
            cnt <= (phase == PH_IDLE || bit_end) ? '0 : cnt + 16'd1;
            case (phase)
                PH_IDLE: if (start) begin
                    phase <= PH_START;
                    sh    <= din;
                    txd   <= 1'b0;
                end
                PH_START: if (bit_end) begin
                    phase <= PH_DATA;
                    txd   <= sh[0];
                end
                PH_DATA: if (bit_end) begin
                    idx   <= idx + 3'd1;
                    sh    <= sh >> 1;
                    txd   <= idx == 3'd7 ? 1'b1 : sh[1];
                    phase <= idx == 3'd7 ? PH_STOP : PH_DATA;
                end
                PH_STOP: if (bit_end) begin
                    phase <= go ? PH_START : PH_IDLE;
                    sh    <= nb;
                    txd   <= !go;
                    pend  <= 1'b0;
                end else if (start) begin
                    pend <= 1'b1;
                    pbuf <= din;
                end
            endcase
        end
    end

endmodule

// File: rtl/vault_share_tx.sv
// vault_share_tx: queues found nonces and sends each as a UART frame
// (sync 0xA5, nonce bytes MSB first, optional XOR checksum byte).
// Ports: clk, rst_n (async, active-low); share (vault_share_if.slave);
// uart_txd serial line (idles high); busy (frame on line or queue
// non-empty); drop_count (saturating count of refused share cycles).
// Macro VAULT_SHARE_CHECKSUM_EN appends the XOR checksum byte.
module vault_share_tx
    import vault_share_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    vault_share_if.slave        share,
    output logic                uart_txd,
    output logic                busy,
    output logic [15:0]         drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          full;
    logic          push;
    logic          pop;
    logic [2:0]    st;
    logic [2:0]    st_nxt;
    logic [2:0]    bsel;
    logic [31:0]   nonce_q;
    logic [7:0]    frame_byte;
    logic          tx_start;
    logic [7:0]    tx_byte;
    tx_phase_e     phase;
    logic          data_done;

    assign full              = cnt == FULL_CNT;
    assign push              = share.share_valid && !full;
    assign pop               = st == S_LOAD;
    assign share.share_ready = !full;
    assign busy              = phase != PH_IDLE || st != S_IDLE || cnt != '0;

`ifdef VAULT_SHARE_CHECKSUM_EN
    assign frame_byte = bsel == 3'd5 ? nonce_xor(nonce_q) : nonce_byte(nonce_q, bsel);
`else
    assign frame_byte = nonce_byte(nonce_q, bsel);
`endif

    // The serializer holds a byte handed over during its stop bit, so STOP,
    // NEXT, IDLE and LOAD all fit inside one stop bit and the line never idles
    // between bytes or between queued frames.
    always_comb begin
        st_nxt   = st;
        tx_start = 1'b0;
        tx_byte  = SYNC_BYTE;
        case (st)
            S_IDLE:  st_nxt = cnt != '0 ? S_LOAD : S_IDLE;
            S_LOAD: begin
                tx_start = 1'b1;
                st_nxt   = S_START;
            end
            S_START: st_nxt = phase == PH_DATA ? S_DATA : S_START;
            S_DATA:  st_nxt = data_done ? S_STOP : S_DATA;
            S_STOP:  st_nxt = S_NEXT;
            S_NEXT: begin
                tx_start = bsel != 3'(FRAME_LEN);
                tx_byte  = frame_byte;
                st_nxt   = tx_start ? S_START : S_IDLE;
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= share.share_nonce;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            bsel       <= '0;
            nonce_q    <= '0;
            cnt        <= '0;
            wp         <= '0;
            rp         <= '0;
            drop_count <= '0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt + (AW + 1)'(push) - (AW + 1)'(pop);
            wp  <= wp + AW'(push);
            rp  <= rp + AW'(pop);
            if (pop) begin
                nonce_q <= mem[rp];
                bsel    <= 3'd1;
            end else if (st == S_NEXT && tx_start) begin
                bsel <= bsel + 3'd1;
            end
            if (share.share_valid && full && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    vault_uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (tx_start),
        .din       (tx_byte),
        .txd       (uart_txd),
        .phase     (phase),
        .data_done (data_done)
    );

endmodule

// File: tb/tb_vault_share_tx.sv
// tb_vault_share_tx: directed self-checking bench for vault_share_tx.
module tb_vault_share_tx;

    localparam int CPB      = 4;
    localparam int BYTE_CYC = 10 * CPB;
`ifdef VAULT_SHARE_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    typedef struct {
        logic [7:0] b;
        int         s;
        bit         ok;
    } rx_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        uart_txd;
    logic        busy;
    logic [15:0] drop_count;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          epoch = 0;
    int          low_cnt = 0;
    rx_t         rx_q[$];
    logic [7:0]  t1_bytes [6] = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    logic [31:0] burst [6] = '{32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C,
                               32'hC0FFEE00, 32'h5A5AA5A5, 32'h77777777};

    vault_share_if sif ();

    vault_share_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .share      (sif),
        .uart_txd   (uart_txd),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (uart_txd === 1'b0) low_cnt <= low_cnt + 1;

    // Line receiver: start edge cycle, mid-bit samples, stop bit sanity.
    initial begin : mon
        rx_t r;
        int  ep;
        forever begin
            @(negedge clk);
            if (rst_n && uart_txd === 1'b0) begin
                ep  = epoch;
                r.s = cyc;
                r.b = '0;
                repeat (CPB / 2) @(negedge clk);
                r.ok = uart_txd === 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    r.b[i] = uart_txd;
                end
                repeat (CPB) @(negedge clk);
                r.ok = r.ok && uart_txd === 1'b1;
                if (ep == epoch) rx_q.push_back(r);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] n, input int k);
        logic [7:0] x = n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
        return k == 0 ? 8'hA5 : k == 5 ? x : n[8 * (4 - k) +: 8];
    endfunction

    task automatic send(input logic [31:0] v, output int acc);
        @(negedge clk);
        sif.share_valid = 1'b1;
        sif.share_nonce = v;
        chk("send_ready", sif.share_ready, 1);
        @(posedge clk);
        #1 acc = cyc;
        sif.share_valid = 1'b0;
        sif.share_nonce = ~v;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("rx_count", rx_q.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget, output int at);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        at = cyc;
        chk("idle", busy, 0);
    endtask

    task automatic chk_frame(input logic [31:0] n, input int base);
        for (int k = 0; k < NB; k++) begin
            chk("frame_byte", rx_q[base + k].b, exp_byte(n, k));
            chk("frame_stop", rx_q[base + k].ok, 1);
            if (base + k > 0) chk("frame_gap", rx_q[base + k].s - rx_q[base + k - 1].s, BYTE_CYC);
        end
    endtask

    initial begin
        int n, s, lc, at;
        sif.share_valid = 1'b0;
        sif.share_nonce = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_txd", uart_txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_ready", sif.share_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // single share: latency, start-bit width, bytes, frame length
        send(32'hDEADBEEF, n);
        lc = 0;
        while (uart_txd !== 1'b0 && lc < 10) begin
            @(negedge clk);
            lc++;
        end
        s = cyc;
        chk("txd_latency", s, n + 2);
        lc = 0;
        while (uart_txd === 1'b0 && lc < 20) begin
            @(negedge clk);
            lc++;
        end
        chk("start_len", lc, CPB);
        wait_rx(NB, NB * BYTE_CYC + 50);
        for (int k = 0; k < NB; k++) chk("t1_byte", rx_q[k].b, t1_bytes[k]);
        for (int k = 1; k < NB; k++) chk("t1_gap", rx_q[k].s - rx_q[k - 1].s, BYTE_CYC);
        wait_idle(100, at);
        chk("t1_len", at - s, NB * BYTE_CYC);
        chk("t1_txd_idle", uart_txd, 1);

        // six shares on consecutive cycles: five accepted, one dropped
        rx_q.delete();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            sif.share_valid = 1'b1;
            sif.share_nonce = burst[i];
            chk("burst_ready", sif.share_ready, i < 5);
            @(negedge clk);
        end
        sif.share_valid = 1'b0;
        chk("burst_drop", drop_count, 1);
        wait_rx(5 * NB, 5 * NB * BYTE_CYC + 100);
        for (int f = 0; f < 5; f++) chk_frame(burst[f], f * NB);
        wait_idle(200, at);
        repeat (50) @(negedge clk);
        chk("burst_total", rx_q.size(), 5 * NB);

        // drop counter saturation
        sif.share_valid = 1'b1;
        sif.share_nonce = 32'h0BADF00D;
        repeat (70000) @(negedge clk);
        sif.share_valid = 1'b0;
        chk("drop_sat", drop_count, 16'hFFFF);
        wait_idle(7 * NB * BYTE_CYC, at);

        // reset during data bits of byte 3 with another share queued
        send(32'hDEADBEEF, n);
        s = n + 2;
        send(32'h13579BDF, at);
        while (cyc < s + 3 * BYTE_CYC + CPB + 1) @(negedge clk);
        chk("pre_rst_txd", uart_txd, 0);
        #2;
        epoch++;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", uart_txd, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", sif.share_ready, 1);
        chk("mid_rst_drop", drop_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        lc = low_cnt;
        repeat (300) @(negedge clk);
        chk("quiet_line", low_cnt - lc, 0);
        chk("quiet_busy", busy, 0);
        chk("quiet_rx", rx_q.size(), 0);

        // fresh share after reset
        send(32'hCAFEF00D, n);
        wait_rx(NB, NB * BYTE_CYC + 50);
        chk_frame(32'hCAFEF00D, 0);
        chk("post_rst_latency", rx_q[0].s, n + 2);
        wait_idle(100, at);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
